// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like port between the fetch and load/store requesters.
// An owner FIFO routes in-order responses back to the requester that issued them.
module mem_req_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        err_unexpected_ok
);
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTSTANDING - 1);
    localparam logic [StW-1:0]  StLimit = StW'(STARVE_LIMIT);

    typedef enum logic {StIdle, StHold} state_e;

    state_e                     state_q, state_d;
    logic                       hold_sel_q, hold_sel_d;
    logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
    logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]            count_q, count_d;
    logic [StW-1:0]             starve_q, starve_d;
    logic                       err_q, err_d;

    logic sel_data, issue, accept, pop;

    // Starvation implies inst_req, so data wins exactly when it requests and inst is not starved.
    always_comb begin
        if (state_q == StHold) begin
            sel_data = hold_sel_q;
            issue    = 1'b1;
        end else begin
            sel_data = data_req && !((starve_q >= StLimit) && inst_req);
            issue    = (count_q < MaxCnt) && (inst_req || data_req);
        end
    end

    always_comb begin
        mem_req   = resetn & issue;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (resetn) begin
            if (sel_data) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_size  = 2'd2;
                mem_addr  = inst_addr;
            end
        end
    end

    assign accept            = mem_req & mem_addr_ok;
    assign pop               = mem_data_ok && (count_q != '0);
    assign inst_addr_ok      = accept & ~sel_data;
    assign data_addr_ok      = accept & sel_data;
    assign inst_data_ok      = pop & ~owner_q[rd_ptr_q];
    assign data_data_ok      = pop & owner_q[rd_ptr_q];
    assign inst_rdata        = mem_rdata;
    assign data_rdata        = mem_rdata;
    assign err_unexpected_ok = err_q;

    always_comb begin
        state_d    = state_q;
        hold_sel_d = hold_sel_q;
        owner_d    = owner_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        starve_d   = starve_q;
        err_d      = err_q | (mem_data_ok && (count_q == '0));

        if (state_q == StIdle) begin
            if (mem_req && !mem_addr_ok) begin
                state_d    = StHold;
                hold_sel_d = sel_data;
            end
        end else if (mem_addr_ok) begin
            state_d = StIdle;
        end

        if (accept) begin
            owner_d[wr_ptr_q] = sel_data;
            wr_ptr_d          = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !accept) begin
            count_d = count_q - 1'b1;
        end

        if (!inst_req || (accept && !sel_data)) begin
            starve_d = '0;
        end else if (accept && (starve_q < StLimit)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            hold_sel_q <= 1'b0;
            owner_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_sel_q <= hold_sel_d;
            owner_q    <= owner_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester and the data (load/store) requester.
- Both requesters use the req / addr_ok / data_ok handshake.
- Sits between the pipeline's fetch and EXE/MEM memory interfaces and the single external memory/bridge port.
- Tracks in-flight transactions in order so each data_ok is routed back to the requester that issued it.
- Data requests have priority; a starvation guard bounds fetch latency.

Parameters:
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered transactions (1..4).
- STARVE_LIMIT, 4: consecutive cycles of inst losing to data before inst gets priority for one grant.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous reset, active-low
- inst_req  in  1  fetch request (read only)
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data returned this cycle
- inst_rdata  out  32  fetch read data
- data_req  in  1  data request
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte write strobes
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data / store completion this cycle
- data_rdata  out  32  load data
- mem_req  out  1  shared port request
- mem_wr  out  1  shared port write
- mem_size  out  2  shared port size
- mem_wstrb  out  4  shared port strobes
- mem_addr  out  32  shared port address
- mem_wdata  out  32  shared port write data
- mem_addr_ok  in  1  memory accepted the request
- mem_data_ok  in  1  memory response, in issue order
- mem_rdata  in  32  response data
- err_unexpected_ok  out  1  sticky: mem_data_ok seen with no transaction outstanding

Behaviour:
- Reset:
  - resetn low asynchronously clears the hold state, owner FIFO pointers, count, starvation counter and err_unexpected_ok.
  - All outputs are 0 while in reset, except rdata outputs, which follow mem_rdata.
- Selection:
  - Controller states are IDLE and HOLD.
  - In IDLE with count < MAX_OUTSTANDING: winner = data if data_req and not starve; else inst if inst_req; else data if data_req.
  - Meaning of starve: the starvation counter has reached STARVE_LIMIT and inst_req = 1.
  - mem_req is combinationally 1 in the same cycle as the winning request.
- Hold:
  - If mem_req = 1 and mem_addr_ok = 0, latch the winner and go to HOLD.
  - In HOLD the same requester is presented: mem_* come from that requester's inputs, and the requester must keep them stable.
  - The other requester is never switched in while in HOLD.
  - HOLD returns to IDLE on mem_addr_ok.
- Mux:
  - mem_* fields come from the selected requester.
  - For inst: mem_wr = 0, mem_size = 2, mem_wstrb = 0, mem_wdata = 0.
- Accept:
  - inst_addr_ok = mem_req & mem_addr_ok & sel==INST; data_addr_ok likewise for DATA.
  - On accept, push the owner bit (0 = inst, 1 = data) into the owner FIFO.
- Full:
  - When count == MAX_OUTSTANDING and not in HOLD, mem_req = 0 and both addr_ok outputs = 0.
  - HOLD cannot begin at full, because issue happens only below full.
- Response:
  - On mem_data_ok with count > 0, pop the FIFO head.
  - head == 0 gives inst_data_ok = 1; head == 1 gives data_data_ok = 1.
  - inst_rdata and data_rdata both equal mem_rdata (broadcast).
- Simultaneous push and pop: count unchanged, both pointers advance. The pop uses the old head, so a response in the same cycle as an accept never goes to the new entry.
- Empty:
  - mem_data_ok with count == 0: no data_ok asserted, FIFO unchanged.
  - err_unexpected_ok set to 1 and held until reset.
- Pointers: wrap modulo MAX_OUTSTANDING; count is clog2(MAX_OUTSTANDING)+1 bits wide.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle where inst_req = 1 and data wins an accept.
  - Clears when an inst request is accepted, or when inst_req = 0.
- Reset mid-operation: all outstanding tracking is discarded. Any later mem_data_ok belonging to pre-reset transactions sets err_unexpected_ok.

Test Plan:
- Single fetch: inst_req = 1 with addr 0x1C000000; mem_addr_ok = 1 in the same cycle; mem_data_ok 2 cycles later with rdata 0x02800C0C. Required: inst_addr_ok = 1 in cycle 0, inst_data_ok = 1 with inst_rdata = 0x02800C0C, data_data_ok stays 0.
- Priority and hold: inst_req and data_req both 1 (store, addr 0x100, wstrb 0xF, wdata 0xDEADBEEF), mem_addr_ok held 0 for 3 cycles. Required: mem_addr = 0x100, mem_wr = 1 stable for all 3 cycles; data_addr_ok is the first accept; inst is accepted next.
- In-order routing: accept inst (A), then data load (B), with MAX_OUTSTANDING = 2. Required: mem_req = 0 while both are outstanding; first mem_data_ok gives inst_data_ok, second gives data_data_ok; count returns to 0.
- Push/pop same cycle: one transaction outstanding; mem_data_ok and a new mem_addr_ok arrive in the same cycle. Required: the old owner receives data_ok and count stays 1.
- Starvation: data_req held 1 continuously, inst_req 1, mem_addr_ok always 1, STARVE_LIMIT = 4. Required: after 4 data accepts the next accept is inst, then data resumes.
- Error/reset: mem_data_ok with nothing outstanding gives err_unexpected_ok = 1 and no data_ok. Asserting resetn = 0 mid-transaction clears err, mem_req and count immediately (asynchronously).
